// File: rtl/fp_add_norm_round.sv
// Add/normalise/round stage of the FP adder, fed by the alignment right-shifter.
// Normalises one bit per cycle and rounds to nearest-even; one operation in flight.
module fp_add_norm_round #(
    parameter int n   = 23,
    parameter int exp = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           sign_a,
    input  logic           sign_b,
    input  logic [exp-1:0] exp_a,
    input  logic [n-1:0]   mant_a,
    input  logic [n-1:0]   mant_b,
    input  logic           b_hidden,
    input  logic           r_in,
    input  logic           s_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           res_sign,
    output logic [exp-1:0] res_exp,
    output logic [n-1:0]   res_mant,
    output logic           ovf
);

    // Working word: carry, hidden, n fraction bits, guard, sticky.
    localparam int ww = n + 4;
    localparam int ew = exp + 1;
    localparam logic [ew-1:0] e_one = {{(ew-1){1'b0}}, 1'b1};
    localparam logic [ew-1:0] e_max = {1'b0, {exp{1'b1}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_reg;
    logic [ww-1:0]   ea_reg;
    logic [ww-1:0]   eb_reg;
    logic [ww-1:0]   w_reg;
    logic [ew-1:0]   e_reg;
    logic            sign_reg;
    logic            sub_reg;
    logic            zero_reg;

    logic            inc;
    logic [n:0]      frac_sum;
    logic [ew-1:0]   e_rnd;
    logic            w_carry;
    logic            w_hidden;

    assign w_carry  = w_reg[ww-1];
    assign w_hidden = w_reg[ww-2];

    // Round-to-nearest-even: guard set and (sticky or fraction LSB odd).
    assign inc      = w_reg[1] & (w_reg[0] | w_reg[2]);
    assign frac_sum = {1'b0, w_reg[n+1:2]} + {{n{1'b0}}, inc};
    assign e_rnd    = e_reg + {{(ew-1){1'b0}}, frac_sum[n]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ea_reg    <= '0;
            eb_reg    <= '0;
            w_reg     <= '0;
            e_reg     <= '0;
            sign_reg  <= 1'b0;
            sub_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res_sign  <= 1'b0;
            res_exp   <= '0;
            res_mant  <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        ea_reg    <= {1'b0, 1'b1, mant_a, 2'b00};
                        eb_reg    <= {1'b0, b_hidden, mant_b, r_in, s_in};
                        e_reg     <= {1'b0, exp_a};
                        sign_reg  <= sign_a;
                        sub_reg   <= sign_a ^ sign_b;
                        zero_reg  <= 1'b0;
                        in_ready  <= 1'b0;
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    // |A| >= |B| upstream, so the difference never goes negative.
                    w_reg     <= sub_reg ? (ea_reg - eb_reg) : (ea_reg + eb_reg);
                    state_reg <= NORM;
                end
                NORM: begin
                    if (w_reg == '0) begin
                        e_reg     <= '0;
                        zero_reg  <= 1'b1;
                        state_reg <= ROUND;
                    end else if (w_carry) begin
                        w_reg <= {1'b0, w_reg[ww-1:2], w_reg[1] | w_reg[0]};
                        e_reg <= e_reg + e_one;
                    end else if (!w_hidden && (e_reg > e_one)) begin
                        w_reg <= {w_reg[ww-2:0], 1'b0};
                        e_reg <= e_reg - e_one;
                    end else if (!w_hidden && (e_reg == e_one)) begin
                        // Denormal result: exponent field 0 keeps the same scale.
                        e_reg     <= '0;
                        state_reg <= ROUND;
                    end else begin
                        state_reg <= ROUND;
                    end
                end
                ROUND: begin
                    res_sign <= zero_reg ? 1'b0 : sign_reg;
                    e_reg    <= e_rnd;
                    if (e_rnd >= e_max) begin
                        res_exp  <= {exp{1'b1}};
                        res_mant <= '0;
                        ovf      <= 1'b1;
                    end else begin
                        res_exp  <= e_rnd[exp-1:0];
                        res_mant <= frac_sum[n-1:0];
                        ovf      <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
